// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin share of the register-file write port plus a pending-write scoreboard.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               rf_we,
  output logic [AW-1:0]      rf_waddr,
  output logic [DW-1:0]      rf_wdata,
  input  logic               iss_valid,
  input  logic [AW-1:0]      iss_addr,
  output logic [2**AW-1:0]   busy
);
  localparam int NR = 2**AW;
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0] rr_q, rr_d, gidx;
  logic [NREQ-1:0] gnt;
  logic hs;
  logic [AW-1:0] a;
  logic [DW-1:0] d;
  logic we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [NR-1:0] busy_q, busy_d, set_m, clr_m;
  always_comb begin
    gnt = '0;
    gidx = '0;
    hs = 1'b0;
    a = '0;
    d = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(rr_q) + k) % NREQ;
      if (!hs && req_valid[idx]) begin
        hs = 1'b1;
        gnt[idx] = 1'b1;
        gidx = PW'(idx);
        a = req_addr[idx*AW +: AW];
        d = req_data[idx*DW +: DW];
      end
    end
  end
  // set is applied after clear so a fresh allocation survives a same-cycle writeback
  always_comb begin
    rr_d = hs ? gidx : rr_q;
    we_d = hs && (a != '0);
    waddr_d = hs ? a : waddr_q;
    wdata_d = hs ? d : wdata_q;
    clr_m = hs ? (NR'(1) << a) : '0;
    set_m = (iss_valid && iss_addr != '0) ? (NR'(1) << iss_addr) : '0;
    busy_d = (busy_q & ~clr_m) | set_m;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= PW'(NREQ - 1);
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q <= '0;
    end else begin
      rr_q <= rr_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q <= busy_d;
    end
  end
  assign req_ready = gnt;
  assign rf_we = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed checks of grant order, write port, r0 suppression, scoreboard and async reset.
module tb_rf_wb_arbiter;
  localparam int NREQ = 3, DW = 32, AW = 5;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic rf_we;
  logic [AW-1:0] rf_waddr, iss_addr = '0;
  logic [DW-1:0] rf_wdata;
  logic iss_valid = 1'b0;
  logic [31:0] busy;
  int n_cmp = 0, n_bad = 0;
  rf_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .iss_valid(iss_valid), .iss_addr(iss_addr), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    logic [2:0] rr_gnt [4];
    logic [4:0] rr_addr [4];
    rr_gnt = '{3'b001, 3'b010, 3'b100, 3'b001};
    rr_addr = '{5'd1, 5'd2, 5'd3, 5'd1};
    #2;
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    #10 rst_n = 1'b1;
    tick;
    req_valid = 3'b001; req_addr[0 +: AW] = 5'd5; req_data[0 +: DW] = 32'hDEADBEEF;
    #1 chk("first_ready", req_ready, 3'b001);
    tick;
    req_valid = '0;
    chk("first_we", rf_we, 1);
    chk("first_waddr", rf_waddr, 5);
    chk("first_wdata", rf_wdata, 32'hDEADBEEF);
    req_valid = 3'b010; req_addr[AW +: AW] = 5'd0; req_data[DW +: DW] = 32'h12345678;
    #1 chk("r0_ready", req_ready, 3'b010);
    tick;
    req_valid = '0;
    chk("r0_we", rf_we, 0);
    chk("r0_busy0", busy[0], 0);
    iss_valid = 1'b1; iss_addr = 5'd7;
    tick;
    iss_valid = 1'b0;
    chk("sb_set7", busy, 32'h80);
    req_valid = 3'b100; req_addr[2*AW +: AW] = 5'd7; req_data[2*DW +: DW] = 32'hAAAA5555;
    #1 chk("sb_wb7_ready", req_ready, 3'b100);
    tick;
    req_valid = '0;
    chk("sb_clr7", busy, 0);
    chk("sb_wb7_we", rf_we, 1);
    chk("sb_wb7_waddr", rf_waddr, 7);
    req_valid = 3'b111;
    req_addr = {5'd3, 5'd2, 5'd1};
    req_data = {32'h33, 32'h22, 32'h11};
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("rr_ready%0d", i), req_ready, rr_gnt[i]);
      tick;
      chk($sformatf("rr_we%0d", i), rf_we, 1);
      chk($sformatf("rr_waddr%0d", i), rf_waddr, rr_addr[i]);
    end
    req_valid = 3'b001; req_addr[0 +: AW] = 5'd9; iss_valid = 1'b1; iss_addr = 5'd9;
    #1 chk("same_ready", req_ready, 3'b001);
    tick;
    chk("same_setwins", busy, 32'h200);
    req_valid = 3'b010; req_addr[AW +: AW] = 5'd9; iss_addr = 5'd4;
    #1 chk("mix1_ready", req_ready, 3'b010);
    tick;
    chk("mix1_busy", busy, 32'h10);
    req_valid = 3'b100; req_addr[2*AW +: AW] = 5'd4; iss_addr = 5'd6;
    #1 chk("mix2_ready", req_ready, 3'b100);
    tick;
    req_valid = '0;
    chk("mix2_busy", busy, 32'h40);
    iss_addr = 5'd4; tick;
    iss_addr = 5'd5; tick;
    iss_addr = 5'd7; tick;
    iss_valid = 1'b0;
    chk("pre_rst_busy", busy, 32'hF0);
    req_valid = 3'b111;
    req_addr = {5'd3, 5'd2, 5'd1};
    tick;
    chk("pre_rst_we", rf_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_we", rf_we, 0);
    chk("mid_rst_waddr", rf_waddr, 0);
    chk("mid_rst_ready", req_ready, 3'b001);
    rst_n = 1'b1;
    tick;
    chk("post_rst_waddr", rf_waddr, 1);
    chk("post_rst_we", rf_we, 1);
    req_valid = '0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port among NREQ writeback sources (ALU, load unit, multiplier) using round-robin arbitration.
- Drives the registered write address, data and enable. The address feeds the register-file write decoder.
- Keeps a 32-entry pending-write scoreboard so issue logic can stall on registers that have an outstanding write.
- Sits between the execute/memory writeback stages and the register file.

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- DW, 32, write data width.
- AW, 5, register address width; the register count is 2**AW = 32.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  writeback request per source.
- req_addr  in  NREQ*AW  destination register per source, packed; source i occupies [i*AW +: AW].
- req_data  in  NREQ*DW  write data per source, packed; source i occupies [i*DW +: DW].
- req_ready  out  NREQ  one-hot grant; the request is consumed in any cycle where valid & ready.
- rf_we  out  1  register-file write enable, registered.
- rf_waddr  out  AW  register-file write address, registered.
- rf_wdata  out  DW  register-file write data, registered.
- iss_valid  in  1  issue stage allocates a destination register.
- iss_addr  in  AW  destination register being allocated.
- busy  out  2**AW  scoreboard; bit r=1 means a write to register r is pending.

Behaviour:
- Reset (async, rst_n=0): rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, rr_ptr=NREQ-1. Because req_ready is combinational, it reads 0 while no source is valid.
- Arbitration is combinational within the cycle:
  - Search sources starting at (rr_ptr+1) mod NREQ, wrapping, and pick the first with req_valid=1.
  - Raise req_ready for that source only. At most one bit is ever set.
  - The port never stalls, so a valid source with top priority is granted in the same cycle.
- rr_ptr update: on a handshake, rr_ptr <= the granted index. With no handshake, rr_ptr holds.
- Write latency is one cycle. On the clock edge after a handshake from source g with address a:
  - rf_waddr <= a and rf_wdata <= data of g.
  - rf_we <= (a != 0).
  - With no handshake, rf_we <= 0 and rf_waddr/rf_wdata hold their previous values.
- Register 0:
  - Writes to r0 are accepted (ready asserted, request consumed) but suppressed (rf_we=0).
  - busy[0] is always 0.
- Scoreboard, updated at each rising edge:
  - set: iss_valid & iss_addr!=0 sets busy[iss_addr].
  - clear: a handshake with address a clears busy[a].
  - Same-cycle set and clear on the same register: set wins (a new producer has been allocated).
  - Set and clear on different registers both take effect.
  - A writeback to a register whose busy bit is 0 is legal: it is written, and busy stays 0.
- Simultaneous requests to the same register from two sources are both served in round-robin order on successive cycles. The later write wins in the register file.
- A reset asserted mid-operation clears all state immediately. Requests pending at that moment are not remembered; sources must re-present them after reset.
- Sources must hold req_valid/addr/data stable until they see ready. The arbiter does not check this.

Test Plan:
- Reset: rst_n=0 -> rf_we=0, rf_waddr=0, busy=0, req_ready=0. Release, then source 0 valid, addr 5, data 0xDEADBEEF -> req_ready=001 the same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
- Round-robin: all 3 sources valid continuously, addrs 1/2/3 -> grants 001,010,100,001 on consecutive cycles; rf_waddr sequence 1,2,3,1; one write per cycle with no bubbles.
- r0 suppression: source 1 valid, addr 0, data 0x12345678 -> req_ready=010; next cycle rf_we=0; busy[0] stays 0.
- Scoreboard set/clear:
  - iss_valid with iss_addr=7 -> busy=0x00000080 next cycle.
  - Later, source 2 writes addr 7 -> busy=0 after that edge.
  - iss addr 9 and writeback addr 9 in the same cycle -> busy[9]=1.
- Mixed set/clear: busy[4]=1; in one cycle issue addr 6 and writeback addr 4 -> busy=0x00000040.
- Reset mid-stream: all sources valid, busy=0x000000F0, assert rst_n=0 between edges -> busy=0 and rf_we=0 without waiting for a clock edge. After release, first grant goes to source 0.
